// File: rtl/vga_frame_sequencer_if.sv
// Control/status bundle between the top-level control logic, the frame
// sequencer and the vga_driver. FRAME_CNT_W must match the sequencer's parameter.
interface vga_frame_sequencer_if #(
  parameter int FRAME_CNT_W = 16
);
  logic                   start;
  logic                   stop;
  logic                   v_sync;
  logic                   drv_en;
  logic                   blank;
  logic [1:0]             pattern_sel;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   frame_start;
  logic [1:0]             state;
  logic                   err;

  // The sequencer is the slave: it takes commands and v_sync, and reports status.
  modport slave (
    input  start, stop, v_sync,
    output drv_en, blank, pattern_sel, frame_cnt, frame_start, state, err
  );

  modport master (
    output start, stop, v_sync,
    input  drv_en, blank, pattern_sel, frame_cnt, frame_start, state, err
  );
endinterface

// File: rtl/vga_frame_sequencer.sv
// Run-time sequencer for the VGA driver: warm-up, pattern rotation, clean stop.
// Optional watchdog enabled by defining VGA_SEQ_WATCHDOG_EN.
module vga_frame_sequencer #(
  parameter int WARMUP_FRAMES   = 2,
  parameter int PAT_HOLD_FRAMES = 60,
  parameter int NUM_PAT         = 4,
  parameter int FRAME_CNT_W     = 16,
  parameter int WDOG_CYCLES     = 700000
) (
  input logic                  clk,
  input logic                  rst,
  vga_frame_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  localparam int WARM_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
  localparam int HOLD_W = (PAT_HOLD_FRAMES > 1) ? $clog2(PAT_HOLD_FRAMES) : 1;

  state_t                 state_q, state_d;
  logic                   drv_en_q, blank_q;
  logic                   v_sync_d, fs_q;
  logic [WARM_W-1:0]      warm_q, warm_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [1:0]             pat_q, pat_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   err_q;
  logic                   clr_run, adv_run;

`ifdef VGA_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_d;
`else
  assign err_q = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    warm_d  = warm_q;
    hold_d  = hold_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    clr_run = 1'b0;
    adv_run = 1'b0;
`ifdef VGA_SEQ_WATCHDOG_EN
    wd_d  = wd_q;
    err_d = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop && !err_q) begin
          warm_d = '0;
          if (WARMUP_FRAMES == 0) begin
            state_d = S_RUN;
            clr_run = 1'b1;
          end else begin
            state_d = S_WARMUP;
          end
        end
      end
      S_WARMUP: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (fs_q) begin
          if (warm_q == WARM_W'(WARMUP_FRAMES - 1)) begin
            state_d = S_RUN;
            clr_run = 1'b1;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        adv_run = fs_q;
        if (bus.stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A fresh start cancels the pending stop; otherwise the next frame ends display.
        adv_run = fs_q;
        if (bus.start && !bus.stop) state_d = S_RUN;
        else if (fs_q)              state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_run) begin
      cnt_d  = '0;
      hold_d = '0;
      pat_d  = '0;
    end else if (adv_run) begin
      cnt_d = cnt_q + 1'b1;
      if (hold_q == HOLD_W'(PAT_HOLD_FRAMES - 1)) begin
        hold_d = '0;
        pat_d  = (pat_q == 2'(NUM_PAT - 1)) ? 2'd0 : pat_q + 2'd1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

`ifdef VGA_SEQ_WATCHDOG_EN
    // A missing v_sync while enabled trips the watchdog and forces the display off.
    if (state_q == S_IDLE || fs_q) begin
      wd_d = '0;
    end else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      wd_d = wd_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= S_IDLE;
      drv_en_q <= 1'b0;
      blank_q  <= 1'b1;
      v_sync_d <= 1'b1;
      fs_q     <= 1'b0;
      warm_q   <= '0;
      hold_q   <= '0;
      pat_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      drv_en_q <= (state_d != S_IDLE);
      blank_q  <= (state_d == S_IDLE) || (state_d == S_WARMUP);
      v_sync_d <= bus.v_sync;
      fs_q     <= drv_en_q & v_sync_d & ~bus.v_sync;
      warm_q   <= warm_d;
      hold_q   <= hold_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef VGA_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`endif

  assign bus.state       = state_q;
  assign bus.drv_en      = drv_en_q;
  assign bus.blank       = blank_q;
  assign bus.pattern_sel = pat_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.frame_start = fs_q;
  assign bus.err         = err_q;

endmodule
